// File: rtl/hit_scorer.sv
// Bullet/tank collision scoring and explosion sequencing for the tank game.
// Optional build macro FRIENDLY_FIRE_EN: a bullet re-entering its own tank scores for the opponent.
module hit_scorer #(
  parameter int TANK_SIZE     = 32,
  parameter int BULLET_SIZE   = 4,
  parameter int WIN_SCORE     = 3,
  parameter int EXPLODE_TICKS = 12500000
) (
  input  logic       clk25,
  input  logic       resetn,
  input  logic [9:0] x_tank1,
  input  logic [8:0] y_tank1,
  input  logic [9:0] x_tank2,
  input  logic [8:0] y_tank2,
  input  logic [9:0] bullet_x1,
  input  logic [8:0] bullet_y1,
  input  logic       bullet_act1,
  input  logic [9:0] bullet_x2,
  input  logic [8:0] bullet_y2,
  input  logic       bullet_act2,
  input  logic       explosion_ack1,
  input  logic       explosion_ack2,
  output logic       explosion_flag,
  output logic       des_bullet1,
  output logic       des_bullet2,
  output logic [1:0] red_score,
  output logic [1:0] green_score,
  output logic [1:0] winner,
  output logic       game_over
);

  localparam int CNT_W = (EXPLODE_TICKS > 1) ? $clog2(EXPLODE_TICKS) : 1;
  localparam int LOAD_VAL = (EXPLODE_TICKS > 0) ? EXPLODE_TICKS - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_VAL);
  localparam logic [1:0] WIN = 2'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE, EXPLODE, WAIT_ACK, OVER} state_t;

  // Box overlap evaluated 11 bits wide so right/bottom edges never wrap.
  function automatic logic overlap(input logic [9:0] bx, input logic [8:0] by,
                                   input logic [9:0] tx, input logic [8:0] ty);
    logic [10:0] bx_e, by_e, tx_e, ty_e;
    logic        ov_x, ov_y;
    bx_e = {1'b0, bx};
    by_e = {2'b00, by};
    tx_e = {1'b0, tx};
    ty_e = {2'b00, ty};
    ov_x = (bx_e + 11'(BULLET_SIZE) > tx_e) && (bx_e < tx_e + 11'(TANK_SIZE));
    ov_y = (by_e + 11'(BULLET_SIZE) > ty_e) && (by_e < ty_e + 11'(TANK_SIZE));
    return ov_x && ov_y;
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] s, input logic inc);
    if (inc && (s < WIN)) return s + 2'd1;
    return s;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit1_q, hit1_d;
  logic             hit2_q, hit2_d;
  logic             self1_q, self1_d;
  logic             self2_q, self2_d;
  logic             ack1_q, ack1_d;
  logic             ack2_q, ack2_d;
  logic             flag_q, flag_d;
  logic             des1_q, des1_d;
  logic             des2_q, des2_d;
  logic [1:0]       red_q, red_d;
  logic [1:0]       green_q, green_d;
  logic [1:0]       winner_q, winner_d;
  logic             over_q, over_d;

  logic red_evt, green_evt, kill1, kill2;

  always_comb begin
    hit1_d = bullet_act1 && overlap(bullet_x1, bullet_y1, x_tank2, y_tank2);
    hit2_d = bullet_act2 && overlap(bullet_x2, bullet_y2, x_tank1, y_tank1);
  end

`ifdef FRIENDLY_FIRE_EN
  logic arm1_q, arm1_d;
  logic arm2_q, arm2_d;
  logic own1, own2;

  // Arm flags drop while a bullet is idle, so a fresh spawn starts disarmed.
  always_comb begin
    own1    = overlap(bullet_x1, bullet_y1, x_tank1, y_tank1);
    own2    = overlap(bullet_x2, bullet_y2, x_tank2, y_tank2);
    arm1_d  = bullet_act1 && (arm1_q || !own1);
    arm2_d  = bullet_act2 && (arm2_q || !own2);
    self1_d = bullet_act1 && own1 && arm1_q;
    self2_d = bullet_act2 && own2 && arm2_q;
  end

  always_ff @(posedge clk25 or negedge resetn) begin
    if (!resetn) begin
      arm1_q <= 1'b0;
      arm2_q <= 1'b0;
    end else begin
      arm1_q <= arm1_d;
      arm2_q <= arm2_d;
    end
  end
`else
  always_comb begin
    self1_d = 1'b0;
    self2_d = 1'b0;
  end
`endif

  // Self-hits credit the opponent but still destroy the offending bullet.
  always_comb begin
    red_evt   = hit1_q || self2_q;
    green_evt = hit2_q || self1_q;
    kill1     = hit1_q || self1_q;
    kill2     = hit2_q || self2_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack1_d   = ack1_q;
    ack2_d   = ack2_q;
    flag_d   = flag_q;
    des1_d   = 1'b0;
    des2_d   = 1'b0;
    red_d    = red_q;
    green_d  = green_q;
    winner_d = winner_q;
    over_d   = over_q;
    case (state_q)
      IDLE: begin
        if (red_evt || green_evt) begin
          des1_d  = kill1;
          des2_d  = kill2;
          red_d   = sat_inc(red_q, red_evt);
          green_d = sat_inc(green_q, green_evt);
          flag_d  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = EXPLODE;
        end
      end
      EXPLODE: begin
        if (cnt_q == '0) state_d = WAIT_ACK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      WAIT_ACK: begin
        if (ack1_q && ack2_q) begin
          ack1_d = 1'b0;
          ack2_d = 1'b0;
          flag_d = 1'b0;
          if ((red_q == WIN) || (green_q == WIN)) begin
            over_d   = 1'b1;
            winner_d = {green_q == WIN, red_q == WIN};
            state_d  = OVER;
          end else begin
            state_d = IDLE;
          end
        end else begin
          ack1_d = ack1_q || explosion_ack1;
          ack2_d = ack2_q || explosion_ack2;
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk25 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hit1_q   <= 1'b0;
      hit2_q   <= 1'b0;
      self1_q  <= 1'b0;
      self2_q  <= 1'b0;
      ack1_q   <= 1'b0;
      ack2_q   <= 1'b0;
      flag_q   <= 1'b0;
      des1_q   <= 1'b0;
      des2_q   <= 1'b0;
      red_q    <= 2'd0;
      green_q  <= 2'd0;
      winner_q <= 2'd0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hit1_q   <= hit1_d;
      hit2_q   <= hit2_d;
      self1_q  <= self1_d;
      self2_q  <= self2_d;
      ack1_q   <= ack1_d;
      ack2_q   <= ack2_d;
      flag_q   <= flag_d;
      des1_q   <= des1_d;
      des2_q   <= des2_d;
      red_q    <= red_d;
      green_q  <= green_d;
      winner_q <= winner_d;
      over_q   <= over_d;
    end
  end

  assign explosion_flag = flag_q;
  assign des_bullet1    = des1_q;
  assign des_bullet2    = des2_q;
  assign red_score      = red_q;
  assign green_score    = green_q;
  assign winner         = winner_q;
  assign game_over      = over_q;

endmodule

// File: tb/tb_hit_scorer.sv
// Scoreboard bench for hit_scorer: directed game scenarios plus randomized shots vs an interval-overlap model.
module tb_hit_scorer;
  localparam int TS = 32, BS = 4, WIN = 3, TICKS = 10;

  logic       clk25 = 1'b0, resetn = 1'b0;
  logic [9:0] x_tank1 = '0, x_tank2 = '0, bullet_x1 = '0, bullet_x2 = '0;
  logic [8:0] y_tank1 = '0, y_tank2 = '0, bullet_y1 = '0, bullet_y2 = '0;
  logic       bullet_act1 = 1'b0, bullet_act2 = 1'b0;
  logic       explosion_ack1 = 1'b0, explosion_ack2 = 1'b0;
  logic       explosion_flag, des_bullet1, des_bullet2, game_over;
  logic [1:0] red_score, green_score, winner;

  always #20 clk25 = ~clk25;

  hit_scorer #(.TANK_SIZE(TS), .BULLET_SIZE(BS), .WIN_SCORE(WIN), .EXPLODE_TICKS(TICKS)) dut (
    .clk25(clk25), .resetn(resetn),
    .x_tank1(x_tank1), .y_tank1(y_tank1), .x_tank2(x_tank2), .y_tank2(y_tank2),
    .bullet_x1(bullet_x1), .bullet_y1(bullet_y1), .bullet_act1(bullet_act1),
    .bullet_x2(bullet_x2), .bullet_y2(bullet_y2), .bullet_act2(bullet_act2),
    .explosion_ack1(explosion_ack1), .explosion_ack2(explosion_ack2),
    .explosion_flag(explosion_flag), .des_bullet1(des_bullet1), .des_bullet2(des_bullet2),
    .red_score(red_score), .green_score(green_score), .winner(winner), .game_over(game_over)
  );

  typedef struct packed {logic d1; logic d2; logic [1:0] red; logic [1:0] green;} exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0, bad = 0;
  int   m_red = 0, m_green = 0;
  bit   m_over = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction
  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction

  // Two boxes touch when their half-open intervals intersect on both axes.
  function automatic bit ovl(int bx, int by, int tx, int ty);
    return (imax(bx, tx) < imin(bx + BS, tx + TS)) && (imax(by, ty) < imin(by + BS, ty + TS));
  endfunction

  function automatic int exp_winner();
    if (!m_over) return 0;
    return ((m_green == WIN) ? 2 : 0) + ((m_red == WIN) ? 1 : 0);
  endfunction

  // Monitor: every destroy pulse must match the oldest expected hit.
  always @(negedge clk25) begin
    if (resetn && (des_bullet1 || des_bullet2)) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_des: des1=%0b des2=%0b expected no pulse (t=%0t)", des_bullet1, des_bullet2, $time);
      end else begin
        mon_e = sbq.pop_front();
        check("des1", des_bullet1, mon_e.d1);
        check("des2", des_bullet2, mon_e.d2);
        check("red_at_hit", red_score, mon_e.red);
        check("green_at_hit", green_score, mon_e.green);
        check("flag_at_hit", explosion_flag, 1);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_flag"}, explosion_flag, 0);
    check({tag, "_red"}, red_score, m_red);
    check({tag, "_green"}, green_score, m_green);
    check({tag, "_over"}, game_over, m_over);
    check({tag, "_winner"}, winner, exp_winner());
  endtask

  task automatic do_reset();
    @(negedge clk25); #3;
    resetn = 1'b0;
    #1;
    check("async_reset_outputs",
          {explosion_flag, des_bullet1, des_bullet2, red_score, green_score, winner, game_over}, 0);
    m_red = 0; m_green = 0; m_over = 0;
    check("sb_empty_at_reset", sbq.size(), 0);
    sbq.delete();
    explosion_ack1 = 1'b0; explosion_ack2 = 1'b0;
    @(negedge clk25); @(negedge clk25);
    resetn = 1'b1;
  endtask

  task automatic drive_pos(input int tx1, ty1, tx2, ty2, bx1, by1, bx2, by2);
    x_tank1 = 10'(tx1); y_tank1 = 9'(ty1); x_tank2 = 10'(tx2); y_tank2 = 9'(ty2);
    bullet_x1 = 10'(bx1); bullet_y1 = 9'(by1); bullet_x2 = 10'(bx2); bullet_y2 = 9'(by2);
  endtask

  // Entered at the negedge where the flag first shows; runs explosion and the ack handshake.
  task automatic explode_and_ack(input int gap, input bit ack1_first, input bit level);
    int fr = 0;
    for (int i = 3; i <= 12; i++) begin
      @(negedge clk25);
      if (i == 4) begin explosion_ack1 = 1'b1; explosion_ack2 = 1'b1; end
      if (i == 5) begin explosion_ack1 = 1'b0; explosion_ack2 = 1'b0; end
      if (explosion_flag) fr++;
    end
    check("flag_through_explode", fr, 10);
    if (ack1_first) explosion_ack1 = 1'b1; else explosion_ack2 = 1'b1;
    for (int k = 1; k <= gap; k++) begin
      @(negedge clk25);
      if (k == 1 && !level) begin explosion_ack1 = 1'b0; explosion_ack2 = 1'b0; end
      if (k < gap) check("flag_wait_ack", explosion_flag, 1);
    end
    if (ack1_first) explosion_ack2 = 1'b1; else explosion_ack1 = 1'b1;
    @(negedge clk25);
    if (!level) begin explosion_ack1 = 1'b0; explosion_ack2 = 1'b0; end
    check("flag_after_last_ack", explosion_flag, 1);
    @(negedge clk25);
    explosion_ack1 = 1'b0; explosion_ack2 = 1'b0;
    if (m_red == WIN || m_green == WIN) m_over = 1;
    check_idle_outputs("post_ack");
  endtask

  task automatic shot(input int tx1, ty1, tx2, ty2, bx1, by1, bx2, by2,
                      input bit a1, a2, input int gap, input bit ack1_first, input bit level);
    bit e1, e2;
    e1 = a1 && ovl(bx1, by1, tx2, ty2) && !m_over;
    e2 = a2 && ovl(bx2, by2, tx1, ty1) && !m_over;
    @(posedge clk25); #1;
    drive_pos(tx1, ty1, tx2, ty2, bx1, by1, bx2, by2);
    bullet_act1 = a1; bullet_act2 = a2;
    if (e1 || e2) begin
      m_red   = imin(m_red + int'(e1), WIN);
      m_green = imin(m_green + int'(e2), WIN);
      sbq.push_back('{e1, e2, 2'(m_red), 2'(m_green)});
    end
    @(posedge clk25); #1;
    bullet_act1 = 1'b0; bullet_act2 = 1'b0;
    @(negedge clk25);
    check("flag_one_cycle_after_input", explosion_flag, 0);
    if (!(e1 || e2)) begin
      repeat (3) @(negedge clk25);
      check_idle_outputs("nohit");
      return;
    end
    @(negedge clk25);
    check("flag_two_cycles_after_input", explosion_flag, 1);
    explode_and_ack(gap, ack1_first, level);
  endtask

  task automatic random_shot();
    int tx1, ty1, tx2, ty2, bx1, by1, bx2, by2;
    tx1 = $urandom_range(8, 600); ty1 = $urandom_range(8, 440);
    tx2 = $urandom_range(8, 600); ty2 = $urandom_range(8, 440);
    if ($urandom_range(0, 1)) begin
      bx1 = tx2 + $urandom_range(0, 40) - 6; by1 = ty2 + $urandom_range(0, 40) - 6;
    end else begin
      bx1 = $urandom_range(0, 1000); by1 = $urandom_range(0, 500);
    end
    if ($urandom_range(0, 1)) begin
      bx2 = tx1 + $urandom_range(0, 40) - 6; by2 = ty1 + $urandom_range(0, 40) - 6;
    end else begin
      bx2 = $urandom_range(0, 1000); by2 = $urandom_range(0, 500);
    end
    shot(tx1, ty1, tx2, ty2, bx1, by1, bx2, by2,
         $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
         $urandom_range(0, 5), $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  initial begin
    // Reset held with active overlapping bullets: nothing may leave the block.
    drive_pos(300, 200, 100, 100, 110, 110, 310, 210);
    bullet_act1 = 1'b1; bullet_act2 = 1'b1;
    repeat (4) begin
      @(negedge clk25);
      check("reset_held_outputs",
            {explosion_flag, des_bullet1, des_bullet2, red_score, green_score, winner, game_over}, 0);
    end
    bullet_act1 = 1'b0; bullet_act2 = 1'b0;
    @(negedge clk25);
    resetn = 1'b1;

    // Red wins 3-0, including the pixel-exact edge case.
    shot(300, 200, 100, 100, 110, 110, 0, 0, 1, 0, 5, 0, 0);
    shot(300, 200, 100, 100, 96, 110, 0, 0, 1, 0, 0, 1, 0);
    shot(300, 200, 100, 100, 97, 110, 0, 0, 1, 0, 2, 1, 1);
    shot(300, 200, 100, 100, 120, 128, 0, 0, 1, 0, 0, 0, 0);
    check("red_win_over", game_over, 1);
    check("red_win_winner", winner, 1);
    shot(300, 200, 100, 100, 110, 110, 310, 210, 1, 1, 1, 0, 0);
    shot(300, 200, 100, 100, 110, 110, 310, 210, 1, 1, 1, 0, 0);
    do_reset();

    // Simultaneous hits every round end in a draw.
    repeat (3) shot(300, 200, 100, 100, 110, 110, 310, 210, 1, 1, 3, 1, 0);
    check("draw_winner", winner, 3);
    do_reset();

    // Reset in the middle of an explosion.
    @(posedge clk25); #1;
    drive_pos(300, 200, 100, 100, 110, 110, 0, 0);
    bullet_act1 = 1'b1;
    sbq.push_back('{1'b1, 1'b0, 2'd1, 2'd0});
    @(posedge clk25); #1;
    bullet_act1 = 1'b0;
    repeat (4) @(negedge clk25);
    check("mid_explode_flag", explosion_flag, 1);
    do_reset();
    repeat (2) @(negedge clk25);
    check_idle_outputs("after_mid_reset");

`ifdef FRIENDLY_FIRE_EN
    // Spawned inside own tank: no self-hit until it has left and come back.
    @(posedge clk25); #1;
    drive_pos(200, 200, 500, 50, 210, 210, 0, 0);
    bullet_act1 = 1'b1;
    repeat (4) @(negedge clk25);
    check("ff_spawn_no_hit", explosion_flag, 0);
    @(posedge clk25); #1;
    bullet_x1 = 10'd250;
    repeat (2) @(posedge clk25);
    #1;
    bullet_x1 = 10'd210;
    m_green = 1;
    sbq.push_back('{1'b1, 1'b0, 2'd0, 2'd1});
    @(posedge clk25); #1;
    bullet_act1 = 1'b0;
    @(negedge clk25);
    check("ff_flag_pre", explosion_flag, 0);
    @(negedge clk25);
    check("ff_flag_rise", explosion_flag, 1);
    explode_and_ack(2, 1, 0);
    do_reset();
`endif

    for (int n = 0; n < 40; n++) begin
      if (m_over && $urandom_range(0, 2) == 0) do_reset();
      random_shot();
    end

    repeat (3) @(negedge clk25);
    check("sb_empty_at_end", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
